// File: rtl/trace_event_counter_bank_pkg.sv
// Shared types for the trace performance-counter bank: core trace event vector,
// register index map and CTRL layout.
package cva5_types;

  typedef struct packed {
    logic mul_stall;
    logic div_stall;
    logic ls_stall;
    logic fetch_stall;
    logic num_of_instructions_pending_writeback;
    logic num_instructions_in_flight;
    logic num_instructions_completing;
    logic rs1_and_rs2_forwarding_needed;
    logic rs2_forwarding_needed;
    logic rs1_forwarding_needed;
    logic div_operand_stall;
    logic ls_operand_stall;
    logic alu_operand_stall;
    logic branch_operand_stall;
    logic instruction_issued_dec;
    logic other_stall;
    logic no_instruction_stall;
    logic no_id_stall;
    logic unit_stall;
    logic operand_stall;
    logic misc_op;
    logic store_op;
    logic load_op;
    logic branch_or_jump_op;
    logic alu_op;
    logic mul_op;
    logic div_op;
    logic load_conflict_delay;
    logic return_correct;
    logic return_misspredict;
    logic branch_correct;
    logic branch_misspredict;
    logic early_branch_correction;
  } cva5_trace_events_t;

  localparam int EVENT_W = $bits(cva5_trace_events_t);

  localparam int PMC_CTRL     = 0;
  localparam int PMC_OVF      = 1;
  localparam int PMC_SEL_BASE = 2;
  localparam int PMC_STRIDE   = 3;
  localparam int PMC_CNT_OFS  = 1;
  localparam int PMC_SNAP_OFS = 2;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_SNAP_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  typedef struct packed {
    logic irq_en;
    logic snapshot;
    logic global_en;
  } pmc_ctrl_t;

  function automatic int pmc_addr_w(int num_counters);
    return $clog2(PMC_SEL_BASE + PMC_STRIDE * num_counters);
  endfunction

endpackage

// File: rtl/trace_event_counter_bank_if.sv
// Register access bus of the counter bank: strobed writes, one-cycle-latency reads.
interface trace_event_counter_bank_if
  import cva5_types::*;
#(
  parameter int NUM_COUNTERS = 4
) ();
  localparam int ADDR_W = pmc_addr_w(NUM_COUNTERS);

  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wr_data;
  logic              rd_valid;
  logic [31:0]       rd_data;

  modport master (output wr_en, rd_en, addr, wr_data, input rd_valid, rd_data);
  modport slave  (input wr_en, rd_en, addr, wr_data, output rd_valid, rd_data);
endinterface

// File: rtl/trace_event_counter_bank_pmc_counter.sv
// One event counter: event select, increment with write override, wrap pulse
// and snapshot register.
module pmc_counter
  import cva5_types::*;
#(
  parameter int COUNTER_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [EVENT_W-1:0]   ev_i,
  input  logic                 sel_we_i,
  input  logic                 cnt_we_i,
  input  logic [COUNTER_W-1:0] wdata_i,
  input  logic                 snap_i,
  output logic [5:0]           sel_o,
  output logic [COUNTER_W-1:0] cnt_o,
  output logic [COUNTER_W-1:0] snap_o,
  output logic                 ovf_o
);
  logic [5:0]           sel_q, sel_d;
  logic [COUNTER_W-1:0] cnt_q, cnt_d;
  logic [COUNTER_W-1:0] snap_q, snap_d;
  logic [63:0]          ev_pad;
  logic                 hit;

  // Padding keeps the select mux in range for any 6-bit index.
  assign ev_pad = 64'(ev_i);
  assign hit    = en_i && (sel_q < 6'(EVENT_W)) && ev_pad[sel_q];

  always_comb begin
    sel_d  = sel_we_i ? wdata_i[5:0] : sel_q;
    snap_d = snap_i ? cnt_q : snap_q;
    cnt_d  = cnt_q;
    ovf_o  = 1'b0;
    if (cnt_we_i) begin
      cnt_d = wdata_i;
    end else if (hit) begin
      cnt_d = cnt_q + COUNTER_W'(1);
      ovf_o = &cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= 6'(EVENT_W);
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign sel_o  = sel_q;
  assign cnt_o  = cnt_q;
  assign snap_o = snap_q;
endmodule

// File: rtl/trace_event_counter_bank.sv
// Performance-counter bank on the core trace event vector: registered events,
// CTRL/OVF registers, read mux and overflow interrupt.
module trace_event_counter_bank
  import cva5_types::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  cva5_trace_events_t               events,
  trace_event_counter_bank_if.slave        bus,
  output logic                             irq
);
  localparam int ADDR_W = pmc_addr_w(NUM_COUNTERS);

  logic [EVENT_W-1:0]      ev_q;
  pmc_ctrl_t               ctrl_q, ctrl_d;
  logic [NUM_COUNTERS-1:0] ovf_q, ovf_d, ovf_set;
  logic                    rd_valid_q;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    irq_q;
  logic                    wr_ctrl, wr_ovf, snap_take;
  logic                    unused_wdata;

  logic [5:0]              sel_w  [NUM_COUNTERS];
  logic [COUNTER_W-1:0]    cnt_w  [NUM_COUNTERS];
  logic [COUNTER_W-1:0]    snap_w [NUM_COUNTERS];

  assign wr_ctrl      = bus.wr_en && (bus.addr == ADDR_W'(PMC_CTRL));
  assign wr_ovf       = bus.wr_en && (bus.addr == ADDR_W'(PMC_OVF));
  assign snap_take    = wr_ctrl && bus.wr_data[CTRL_SNAP_BIT];
  assign unused_wdata = ^bus.wr_data;

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    localparam int SEL_A = PMC_SEL_BASE + PMC_STRIDE * i;
    pmc_counter #(.COUNTER_W(COUNTER_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (ctrl_q.global_en),
      .ev_i     (ev_q),
      .sel_we_i (bus.wr_en && (bus.addr == ADDR_W'(SEL_A))),
      .cnt_we_i (bus.wr_en && (bus.addr == ADDR_W'(SEL_A + PMC_CNT_OFS))),
      .wdata_i  (bus.wr_data[COUNTER_W-1:0]),
      .snap_i   (snap_take),
      .sel_o    (sel_w[i]),
      .cnt_o    (cnt_w[i]),
      .snap_o   (snap_w[i]),
      .ovf_o    (ovf_set[i])
    );
  end

  // A fresh overflow beats a simultaneous write-1-to-clear.
  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      ctrl_d.global_en = bus.wr_data[CTRL_EN_BIT];
      ctrl_d.irq_en    = bus.wr_data[CTRL_IRQ_EN_BIT];
    end
    ctrl_d.snapshot = 1'b0;
    ovf_d = ovf_q;
    if (wr_ovf) ovf_d = ovf_d & ~bus.wr_data[NUM_COUNTERS-1:0];
    ovf_d = ovf_d | ovf_set;
  end

  always_comb begin
    rd_data_d = '0;
    if (bus.addr == ADDR_W'(PMC_CTRL)) begin
      rd_data_d = 32'({ctrl_q.irq_en, 1'b0, ctrl_q.global_en});
    end else if (bus.addr == ADDR_W'(PMC_OVF)) begin
      rd_data_d = 32'(ovf_q);
    end
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (bus.addr == ADDR_W'(PMC_SEL_BASE + PMC_STRIDE * i))
        rd_data_d = 32'(sel_w[i]);
      if (bus.addr == ADDR_W'(PMC_SEL_BASE + PMC_STRIDE * i + PMC_CNT_OFS))
        rd_data_d = 32'(cnt_w[i]);
      if (bus.addr == ADDR_W'(PMC_SEL_BASE + PMC_STRIDE * i + PMC_SNAP_OFS))
        rd_data_d = 32'(snap_w[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_q       <= '0;
      ctrl_q     <= '0;
      ovf_q      <= '0;
      irq_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ev_q       <= events;
      ctrl_q     <= ctrl_d;
      ovf_q      <= ovf_d;
      irq_q      <= ctrl_q.irq_en & (|ovf_q);
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_trace_event_counter_bank.sv
// Directed bench for the counter bank: reads are scored against a queue of
// hand-computed values by a separate monitor process.
module tb_trace_event_counter_bank;
  import cva5_types::*;

  localparam int NC = 4;
  localparam int CW = 8;
  localparam int AW = pmc_addr_w(NC);

  logic               clk = 1'b0;
  logic               rst_n;
  cva5_trace_events_t ev;
  logic               irq;

  trace_event_counter_bank_if #(.NUM_COUNTERS(NC)) bus ();

  trace_event_counter_bank #(.NUM_COUNTERS(NC), .COUNTER_W(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .events (ev),
    .bus    (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_valid: got rd_data 0x%0h at cycle %0d, expected no read", bus.rd_data, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.rd_data !== e.val || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d", e.name, bus.rd_data, cyc, e.val, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got no rd_valid by cycle %0d, expected 0x%0h", e.name, cyc, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, logic [31:0] d);
    bus.wr_en = 1'b1; bus.addr = AW'(a); bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(string nm, int a, logic [31:0] v);
    bus.rd_en = 1'b1; bus.addr = AW'(a);
    sb.push_back('{nm, v, cyc + 1});
    step();
    bus.rd_en = 1'b0;
  endtask

  task automatic rdwr(string nm, int a, logic [31:0] d, logic [31:0] v);
    bus.rd_en = 1'b1; bus.wr_en = 1'b1; bus.addr = AW'(a); bus.wr_data = d;
    sb.push_back('{nm, v, cyc + 1});
    step();
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ev = '0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
    fork
      monitor();
      begin
        // Reset state
        repeat (2) step();
        check("reset_rd_valid", 32'(bus.rd_valid), 0);
        check("reset_rd_data", bus.rd_data, 0);
        check("reset_irq", 32'(irq), 0);
        rst_n = 1'b1;
        step();
        rd("rst_ctrl", 0, 0);
        rd("rst_ovf", 1, 0);
        rd("rst_sel0", 2, 33);
        rd("rst_cnt0", 3, 0);
        rd("unmapped14", 14, 0);
        rd("unmapped15", 15, 0);

        // alu_op counting and first-increment latency
        wr(2, 8);
        wr(0, 1);
        ev.alu_op = 1'b1; step(); ev.alu_op = 1'b0;
        rd("cnt0_lat_before", 3, 0);
        rd("cnt0_lat_after", 3, 1);
        repeat (4) begin
          ev.alu_op = 1'b1; step(); ev.alu_op = 1'b0; step();
        end
        rd("cnt0_five", 3, 5);

        // Wrap, sticky overflow, irq rise and W1C fall
        wr(6, 'hFE);
        wr(5, 0);
        wr(0, 5);
        ev.early_branch_correction = 1'b1; step(); ev.early_branch_correction = 1'b0; step();
        ev.early_branch_correction = 1'b1; step(); ev.early_branch_correction = 1'b0; step();
        check("irq_lag", 32'(irq), 0);
        step();
        check("irq_set", 32'(irq), 1);
        ev.early_branch_correction = 1'b1; step(); ev.early_branch_correction = 1'b0; step();
        rd("cnt1_wrapped", 6, 1);
        rd("ovf_set", 1, 2);
        wr(1, 2);
        check("irq_hold_after_w1c", 32'(irq), 1);
        step();
        check("irq_drop", 32'(irq), 0);
        rd("ovf_cleared", 1, 0);
        wr(6, 'h1AB);
        rd("cnt1_truncate", 6, 'hAB);
        wr(6, 'hFF);
        ev.early_branch_correction = 1'b1; step(); ev.early_branch_correction = 1'b0;
        wr(1, 2);
        rd("ovf_set_wins", 1, 2);
        wr(1, 2);
        rd("ovf_cleared2", 1, 0);

        // Counter write overrides a concurrent increment
        ev.alu_op = 1'b1;
        step(); step();
        wr(3, 100);
        rd("cnt0_w100", 3, 100);
        rd("cnt0_101", 3, 101);
        rd("cnt0_102", 3, 102);
        rdwr("cnt0_rdwr_prewrite", 3, 50, 103);
        ev.alu_op = 1'b0;
        rd("cnt0_50", 3, 50);
        rd("cnt0_51", 3, 51);

        // Snapshot with live counters advancing, then freeze
        wr(0, 0);
        wr(3, 10);
        wr(6, 20);
        wr(5, 8);
        ev.alu_op = 1'b1;
        step();
        wr(0, 1);
        wr(0, 3);
        rd("snap0", 4, 10);
        rd("snap1", 7, 20);
        rd("cnt0_live", 3, 13);
        rd("cnt1_live", 6, 24);
        wr(0, 0);
        rd("cnt0_frozen", 3, 16);
        rd("cnt1_frozen", 6, 26);
        step(); step();
        rd("cnt0_still", 3, 16);
        rd("ctrl_snap_reads0", 0, 0);
        wr(4, 77);
        rd("snap0_readonly", 4, 10);

        // Disabled select, top valid select, async reset mid-count
        wr(6, 'hFF);
        wr(8, 40);
        wr(11, 32);
        ev = '1;
        wr(0, 5);
        step(); step(); step();
        check("irq_before_reset", 32'(irq), 1);
        rd("cnt2_disabled", 9, 0);
        rd("sel2_readback", 8, 40);
        rd("ovf_cnt1", 1, 2);
        rd("cnt3_sel32", 12, 6);
        bus.rd_en = 1'b1; bus.addr = AW'(3);
        step();
        bus.rd_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_rd_valid", 32'(bus.rd_valid), 0);
        check("async_rst_rd_data", bus.rd_data, 0);
        check("async_rst_irq", 32'(irq), 0);
        ev = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        rd("post_rst_ctrl", 0, 0);
        rd("post_rst_ovf", 1, 0);
        rd("post_rst_sel2", 8, 33);
        rd("post_rst_cnt0", 3, 0);
        rd("post_rst_snap1", 7, 0);

        repeat (3) step();
        n_cmp++;
        if (sb.size() != 0) begin
          n_fail++;
          $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    join_any
  end
endmodule
